// File: rtl/fetch_decode_if.sv
// Front-end bus bundle: instruction-memory request/response, downstream
// stall, and the decoded instruction fields handed to the datapath.
interface fetch_decode_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NAME_BITS  = 5,
   parameter int CTRL_BITS  = 4,
   parameter int ADDR_WIDTH = 16
);
   logic                  stall;
   logic                  imem_req;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic                  imem_valid;
   logic [DATA_WIDTH-1:0] imem_data;
   logic [NAME_BITS-1:0]  rs1_out;
   logic [NAME_BITS-1:0]  rs2_out;
   logic [NAME_BITS-1:0]  ws_out;
   logic [CTRL_BITS-1:0]  op_out;
   logic [DATA_WIDTH-1:0] imm_out;
   logic [6:0]            ctrl_out;
   logic [ADDR_WIDTH-1:0] pc_out;
   logic                  halted;
   logic                  illegal;

   // The fetch/decode stage drives requests and decoded fields.
   modport master (
      input  stall, imem_valid, imem_data,
      output imem_req, imem_addr, rs1_out, rs2_out, ws_out, op_out,
             imm_out, ctrl_out, pc_out, halted, illegal
   );

   // Memory plus datapath side.
   modport slave (
      output stall, imem_valid, imem_data,
      input  imem_req, imem_addr, rs1_out, rs2_out, ws_out, op_out,
             imm_out, ctrl_out, pc_out, halted, illegal
   );
endinterface

// File: rtl/fetch_decode.sv
// RV32I subset fetch/decode stage. Holds the PC, fetches one word at a time,
// parks a word in a one-entry skid buffer when the datapath stalls, and
// issues each decoded instruction for exactly one cycle (bubbles otherwise).
// Stops permanently (until reset) on ECALL or an unsupported encoding.
module fetch_decode #(
   parameter int DATA_WIDTH = 32,
   parameter int NAME_BITS  = 5,
   parameter int CTRL_BITS  = 4,
   parameter int ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input logic           clk,
   input logic           rst,
   fetch_decode_if.master bus
);
   typedef enum logic [1:0] {ST_FETCH = 2'd0, ST_HOLD = 2'd1, ST_HALT = 2'd2} state_t;

   localparam logic [CTRL_BITS-1:0] OP_AND = CTRL_BITS'(4'b0000);
   localparam logic [CTRL_BITS-1:0] OP_OR  = CTRL_BITS'(4'b0001);
   localparam logic [CTRL_BITS-1:0] OP_ADD = CTRL_BITS'(4'b0010);
   localparam logic [CTRL_BITS-1:0] OP_SUB = CTRL_BITS'(4'b0110);
   localparam logic [CTRL_BITS-1:0] OP_SLT = CTRL_BITS'(4'b0111);
   localparam logic [DATA_WIDTH-1:0] ECALL_WORD = DATA_WIDTH'(32'h0000_0073);
   localparam logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(32'h0000_0013);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_out_q, pc_out_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;
   logic                  req_q, req_d;
   logic                  halted_q, halted_d, illegal_q, illegal_d;
   logic [NAME_BITS-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, ws_q, ws_d;
   logic [CTRL_BITS-1:0]  op_q, op_d;
   logic [DATA_WIDTH-1:0] imm_q, imm_d;
   logic [6:0]            ctrl_q, ctrl_d;

   // Word being considered for issue: buffered copy in HOLD, live bus otherwise.
   logic [DATA_WIDTH-1:0] word;
   assign word = (state_q == ST_HOLD) ? skid_q : bus.imem_data;

   logic                  dec_legal;
   logic [NAME_BITS-1:0]  dec_rs1, dec_rs2, dec_ws;
   logic [CTRL_BITS-1:0]  dec_op;
   logic [DATA_WIDTH-1:0] dec_imm;
   logic [6:0]            dec_ctrl;
   logic                  take, issue;

   // Decode the candidate word into datapath fields and a legality flag.
   always_comb begin
      dec_legal = 1'b0;
      dec_op    = OP_ADD;
      dec_imm   = '0;
      dec_rs1   = word[19:15];
      dec_rs2   = '0;
      dec_ws    = '0;
      dec_ctrl  = 7'b0000000;
      case (word[6:0])
         7'b0110011: begin
            dec_rs2  = word[24:20];
            dec_ws   = word[11:7];
            dec_ctrl = 7'b1000000;
            if (word[31:25] == 7'b0000000) begin
               case (word[14:12])
                  3'b000:  begin dec_op = OP_ADD; dec_legal = 1'b1; end
                  3'b010:  begin dec_op = OP_SLT; dec_legal = 1'b1; end
                  3'b110:  begin dec_op = OP_OR;  dec_legal = 1'b1; end
                  3'b111:  begin dec_op = OP_AND; dec_legal = 1'b1; end
                  default: dec_legal = 1'b0;
               endcase
            end else if (word[31:25] == 7'b0100000 && word[14:12] == 3'b000) begin
               dec_op    = OP_SUB;
               dec_legal = 1'b1;
            end
         end
         7'b0010011: begin
            dec_ws   = word[11:7];
            dec_imm  = {{(DATA_WIDTH-12){word[31]}}, word[31:20]};
            dec_ctrl = 7'b1100000;
            case (word[14:12])
               3'b000:  begin dec_op = OP_ADD; dec_legal = 1'b1; end
               3'b010:  begin dec_op = OP_SLT; dec_legal = 1'b1; end
               3'b110:  begin dec_op = OP_OR;  dec_legal = 1'b1; end
               3'b111:  begin dec_op = OP_AND; dec_legal = 1'b1; end
               default: dec_legal = 1'b0;
            endcase
         end
         7'b0000011: begin
            dec_ws    = word[11:7];
            dec_imm   = {{(DATA_WIDTH-12){word[31]}}, word[31:20]};
            dec_ctrl  = 7'b1100100;
            dec_legal = (word[14:12] == 3'b010);
         end
         7'b0100011: begin
            dec_rs2   = word[24:20];
            dec_imm   = {{(DATA_WIDTH-12){word[31]}}, word[31:25], word[11:7]};
            dec_ctrl  = 7'b0101000;
            dec_legal = (word[14:12] == 3'b010);
         end
         default: dec_legal = 1'b0;
      endcase
      // Writes to x0 are discarded; the canonical NOP carries no control at all.
      if (dec_ws == '0) dec_ctrl[6] = 1'b0;
      if (word == NOP_WORD) dec_ctrl = 7'b0000000;
   end

   // Next-state logic: accept, park, issue or halt, and form the next outputs.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      skid_d    = skid_q;
      halted_d  = halted_q;
      illegal_d = illegal_q;
      take      = 1'b0;
      issue     = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (req_q && bus.imem_valid) begin
               if (bus.stall) begin
                  skid_d  = bus.imem_data;
                  state_d = ST_HOLD;
               end else begin
                  take = 1'b1;
               end
            end
         end
         ST_HOLD: take = !bus.stall;
         default: take = 1'b0;
      endcase
      if (take) begin
         if (dec_legal) begin
            issue   = 1'b1;
            pc_d    = pc_q + ADDR_WIDTH'(4);
            state_d = ST_FETCH;
         end else begin
            state_d   = ST_HALT;
            halted_d  = 1'b1;
            illegal_d = (word != ECALL_WORD);
         end
      end
      req_d    = (state_d == ST_FETCH);
      rs1_d    = issue ? dec_rs1  : '0;
      rs2_d    = issue ? dec_rs2  : '0;
      ws_d     = issue ? dec_ws   : '0;
      op_d     = issue ? dec_op   : '0;
      imm_d    = issue ? dec_imm  : '0;
      ctrl_d   = issue ? dec_ctrl : 7'b0000000;
      pc_out_d = issue ? pc_q     : '0;
   end

   // State and output registers; reset restarts fetching from RESET_PC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         pc_q      <= RESET_PC;
         skid_q    <= '0;
         req_q     <= 1'b0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         ws_q      <= '0;
         op_q      <= '0;
         imm_q     <= '0;
         ctrl_q    <= 7'b0000000;
         pc_out_q  <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         skid_q    <= skid_d;
         req_q     <= req_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         ws_q      <= ws_d;
         op_q      <= op_d;
         imm_q     <= imm_d;
         ctrl_q    <= ctrl_d;
         pc_out_q  <= pc_out_d;
      end
   end

   assign bus.imem_req  = req_q;
   assign bus.imem_addr = pc_q;
   assign bus.rs1_out   = rs1_q;
   assign bus.rs2_out   = rs2_q;
   assign bus.ws_out    = ws_q;
   assign bus.op_out    = op_q;
   assign bus.imm_out   = imm_q;
   assign bus.ctrl_out  = ctrl_q;
   assign bus.pc_out    = pc_out_q;
   assign bus.halted    = halted_q;
   assign bus.illegal   = illegal_q;
endmodule
